// File: rtl/uart_rx_frontend_if.sv
// Receive-side output bundle of uart_rx_frontend, grouped for the chip top level.
// Handshake: rx_new_o is a valid-only strobe with no ready; the consumer must take rx_data_o in the strobe cycle.
interface uart_rx_frontend_if;
  logic       rx_new_o;
  logic [7:0] rx_data_o;
  logic       frame_error_o;
  logic       busy_o;
  logic [2:0] state_dbg;

  modport master (output rx_new_o, rx_data_o, frame_error_o, busy_o, state_dbg);
  modport slave  (input  rx_new_o, rx_data_o, frame_error_o, busy_o, state_dbg);
endinterface

// File: rtl/uart_rx_frontend.sv
// Oversampling 8N1 UART receiver front end: two-flop synchroniser, mid-bit sampling, byte and framing-error strobes.
// Optional UART_RX_MAJORITY_EN: each sample is the 2-of-3 majority of the synchronised line over three edges.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               rx_i,
  uart_rx_frontend_if.master rx_bus
);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             new_q, new_d;
  logic             fe_q, fe_d;
  logic             sample;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= rx_i;
      s2_q <= s1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Three-sample window: current s2 plus its values at the two preceding edges.
  logic [1:0] hist_q;
  logic [2:0] win;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hist_q <= 2'b11;
    else         hist_q <= {hist_q[0], s2_q};
  end
  assign win    = {hist_q, s2_q};
  assign sample = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
`else
  assign sample = s2_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      new_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      new_q   <= new_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    new_d   = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!s2_q) state_d = ST_START;
      end
      ST_START: begin
        // Half a bit in: a line that is high again was a glitch, not a start bit.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (sample) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {sample, shreg_q[7:1]};
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        // Leaving on the stop sample lets a start bit right at the nominal stop end be caught.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sample) begin
            data_d  = shreg_q;
            new_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (s2_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rx_bus.rx_new_o      = new_q;
  assign rx_bus.rx_data_o     = data_q;
  assign rx_bus.frame_error_o = fe_q;
  assign rx_bus.busy_o        = (state_q != ST_IDLE);
  assign rx_bus.state_dbg     = state_q;
endmodule
